// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit for the CPU datapath.
// Handles unsigned/signed multiply and unsigned/signed divide of WIDTH-bit
// operands, retiring one bit per clock. Results land in hi/lo. Control
// stalls on busy and picks up the result on the one-cycle done pulse.
// The core always works on operand magnitudes. The sign is restored in the
// single FIX cycle that follows the WIDTH iteration steps.

module mul_div_unit #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  // Latched operation context. op_r[1] selects divide, op_r[0] selects signed.
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mag_a;      // |multiplicand| or |dividend|
  logic [WIDTH-1:0] mag_b;      // |multiplier| or |divisor|
  logic [WIDTH-1:0] a_raw;      // original dividend, returned on divide-by-zero
  logic             psign;      // sign of product / quotient
  logic             rsign;      // sign of remainder (follows the dividend)
  logic [CW-1:0]    counter;

  // Working register pair: {hi_w, lo_w} is the running product, or the
  // partial remainder and the dividend/quotient shift register.
  logic [WIDTH-1:0] hi_w;
  logic [WIDTH-1:0] lo_w;

  // Combinational iteration step and FIX-stage results.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               res_dbz;

  // Two's-complement negation of a WIDTH-bit value (wraps, so the most
  // negative value maps to itself).
  function automatic logic signed [WIDTH-1:0] neg_w(input logic signed [WIDTH-1:0] x);
    return -x;
  endfunction

  // Two's-complement negation of a full-width product.
  function automatic logic signed [2*WIDTH-1:0] neg_2w(input logic signed [2*WIDTH-1:0] x);
    return -x;
  endfunction

  // Magnitude of an operand. This is the raw value for unsigned ops. The
  // most negative value has magnitude 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
    return (is_signed && x[WIDTH-1]) ? neg_w(x) : x;
  endfunction

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, WIDTH steps in CALC, one FIX cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (counter == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    step_hi  = hi_w;
    step_lo  = lo_w;
    mul_sum  = {1'b0, hi_w} + (lo_w[0] ? {1'b0, mag_a} : {(WIDTH + 1){1'b0}});
    rem_sh   = {hi_w, lo_w[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, mag_b};
    if (op_r[1]) begin
      // A non-negative difference means the divisor fits: keep it, quotient bit 1.
      if (!rem_diff[WIDTH]) begin
        step_hi = rem_diff[WIDTH-1:0];
        step_lo = {lo_w[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[WIDTH-1:0];
        step_lo = {lo_w[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_w[WIDTH-1:1]};
    end
  end

  // FIX-stage sign correction and divide-by-zero override.
  always_comb begin
    prod_fix = {hi_w, lo_w};
    res_hi   = hi_w;
    res_lo   = lo_w;
    res_dbz  = 1'b0;
    if (op_r[1]) begin
      if (mag_b == '0) begin
        res_hi  = a_raw;
        res_lo  = '1;
        res_dbz = 1'b1;
      end else begin
        res_hi = rsign ? neg_w(hi_w) : hi_w;
        res_lo = psign ? neg_w(lo_w) : lo_w;
      end
    end else begin
      if (psign) prod_fix = neg_2w({hi_w, lo_w});
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // Datapath and handshake registers. Everything clears on reset, so an
  // in-flight operation is simply dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_r    <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      a_raw   <= '0;
      psign   <= 1'b0;
      rsign   <= 1'b0;
      counter <= '0;
      hi_w    <= '0;
      lo_w    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      dbz     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r    <= op;
            mag_a   <= mag(a, op[0]);
            mag_b   <= mag(b, op[0]);
            a_raw   <= a;
            psign   <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            rsign   <= op[0] & a[WIDTH-1];
            counter <= CW'(WIDTH);
            hi_w    <= '0;
            lo_w    <= op[1] ? mag(a, op[0]) : mag(b, op[0]);
            busy    <= 1'b1;
          end
        end
        CALC: begin
          counter <= counter - CW'(1);
          hi_w    <= step_hi;
          lo_w    <= step_lo;
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          dbz  <= res_dbz;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table plus hand-written handshake, reset
// and WIDTH=8 sequences for mul_div_unit.

module tb_mul_div_unit;

  localparam logic [1:0] MULU = 2'b00;
  localparam logic [1:0] MUL  = 2'b01;
  localparam logic [1:0] DIVU = 2'b10;
  localparam logic [1:0] DIV  = 2'b11;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, dbz;
  logic [15:0] hi, lo;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int n_tests = 0;
  int n_fail  = 0;

  mul_div_unit #(.WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbz(dbz)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dbz(dbz8)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Launch one op on the WIDTH=16 unit and wait (bounded) for done.
  // lat counts posedges after the accepting edge; bcnt counts busy samples.
  task automatic run_op(input logic [1:0] o, input logic [15:0] aa, input logic [15:0] bb,
                        output int lat, output int bcnt);
    @(negedge clock);
    op = o; a = aa; b = bb; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  int lat, bcnt, cnt;

  initial begin
    vecs[0] = '{"mulu_ffff", MULU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0};
    vecs[1] = '{"mul_m3x7",  MUL,  16'hFFFD, 16'h0007, 16'hFFFF, 16'hFFEB, 1'b0};
    vecs[2] = '{"div_m7d2",  DIV,  16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0};
    vecs[3] = '{"divu_7d5",  DIVU, 16'h0007, 16'h0005, 16'h0002, 16'h0001, 1'b0};
    vecs[4] = '{"divu_dbz",  DIVU, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1};
    vecs[5] = '{"div_ovf",   DIV,  16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
    vecs[6] = '{"mul_minsq", MUL,  16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0};
    vecs[7] = '{"div_7dm2",  DIV,  16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0};

    // Reset state
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi",   {16'b0, hi},   32'd0);
    chk("rst_lo",   {16'b0, lo},   32'd0);
    chk("rst_dbz",  {31'b0, dbz},  32'd0);
    chk("rst8_hilo", {16'b0, hi8, lo8}, 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      chk({vecs[i].name, ".lat"},  lat,  32'd17);
      chk({vecs[i].name, ".busy"}, bcnt, 32'd17);
      chk({vecs[i].name, ".hi"},   {16'b0, hi}, {16'b0, vecs[i].hi});
      chk({vecs[i].name, ".lo"},   {16'b0, lo}, {16'b0, vecs[i].lo});
      chk({vecs[i].name, ".dbz"},  {31'b0, dbz}, {31'b0, vecs[i].dbz});
      @(posedge clock); #1;
      chk({vecs[i].name, ".done1"}, {31'b0, done}, 32'd0);
      chk({vecs[i].name, ".hold"},  {hi, lo}, {vecs[i].hi, vecs[i].lo});
    end

    // start re-pulsed mid-operation with new operands: ignored
    @(negedge clock);
    op = MULU; a = 16'h0012; b = 16'h0034; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    repeat (5) begin @(posedge clock); #1; lat++; end
    @(negedge clock);
    op = DIVU; a = 16'hFFFF; b = 16'h0001; start = 1'b1;
    @(posedge clock); #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin @(posedge clock); #1; lat++; end
    chk("ign.lat", lat, 32'd17);
    chk("ign.hilo", {hi, lo}, 32'h0000_03A8);
    cnt = 0;
    repeat (20) begin @(posedge clock); #1; if (done || busy) cnt++; end
    chk("ign.no_queue", cnt, 32'd0);

    // start held through the done cycle: back-to-back accept
    @(negedge clock);
    op = MULU; a = 16'd5; b = 16'd6; start = 1'b1;
    @(posedge clock); #1;
    lat = 0;
    repeat (3) begin @(posedge clock); #1; lat++; end
    op = DIVU; a = 16'd100; b = 16'd7;
    while (!done && lat < 40) begin @(posedge clock); #1; lat++; end
    chk("b2b.lat1", lat, 32'd17);
    chk("b2b.res1", {hi, lo}, 32'h0000_001E);
    @(posedge clock); #1;
    start = 1'b0;
    chk("b2b.acc_busy", {31'b0, busy}, 32'd1);
    chk("b2b.acc_done", {31'b0, done}, 32'd0);
    lat = 0;
    while (!done && lat < 40) begin @(posedge clock); #1; lat++; end
    chk("b2b.lat2", lat, 32'd17);
    chk("b2b.res2", {hi, lo}, 32'h0002_000E);

    // Asynchronous reset in the middle of a divide
    run_op(DIVU, 16'h0055, 16'h0000, lat, bcnt);
    chk("pre_rst.dbz", {31'b0, dbz}, 32'd1);
    chk("pre_rst.hilo", {hi, lo}, 32'h0055_FFFF);
    @(negedge clock);
    op = DIVU; a = 16'h1234; b = 16'h0003; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.busy", {31'b0, busy}, 32'd0);
    chk("arst.done", {31'b0, done}, 32'd0);
    chk("arst.hilo", {hi, lo}, 32'd0);
    chk("arst.dbz",  {31'b0, dbz}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cnt = 0;
    repeat (25) begin @(posedge clock); #1; if (done || busy) cnt++; end
    chk("arst.no_done", cnt, 32'd0);
    run_op(MULU, 16'd3, 16'd4, lat, bcnt);
    chk("arst.fresh_lat", lat, 32'd17);
    chk("arst.fresh", {hi, lo}, 32'h0000_000C);

    // WIDTH=8 instance: signed most-negative squared
    @(negedge clock);
    op8 = MUL; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin @(posedge clock); #1; lat++; end
    chk("w8.lat", lat, 32'd9);
    chk("w8.prod", {16'b0, hi8, lo8}, 32'h0000_4000);
    chk("w8.dbz", {31'b0, dbz8}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
